// File: rtl/ternary_stream_feeder_pkg.sv
// Shared constants, FSM state type and coefficient code points for the ternary stream feeder.
package ternary_stream_feeder_pkg;

  localparam int unsigned NUM_COEF      = 700;
  localparam int unsigned COEF_PER_WORD = 4;
  localparam int unsigned NUM_N         = 701;
  localparam int unsigned NUM_WORDS     = NUM_COEF / COEF_PER_WORD;

  // Counter widths: 10 bits covers 0..699, 8 bits covers 0..174.
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned WORD_W = 8;

  // 2-bit coefficient codes as they arrive on in_data.
  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_POS  = 2'b01;
  localparam logic [1:0] CODE_NEG  = 2'b10;
  localparam logic [1:0] CODE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLoaded,
    StStart,
    StStream,
    StDone
  } state_e;

endpackage

// File: rtl/ternary_stream_feeder_decode.sv
// Combinational 2-bit code decoder: rin[0] = nonzero, rin[1] = negative, illegal flags code 11.
module ternary_decode (
  input  logic [1:0] code,
  output logic [1:0] rin,
  output logic       illegal
);
  import ternary_stream_feeder_pkg::*;

  // Map code to the multiplier's {negative, nonzero} pair; illegal codes stream as zero.
  always_comb begin
    rin     = 2'b00;
    illegal = 1'b0;
    unique case (code)
      CODE_ZERO: rin = 2'b00;
      CODE_POS:  rin = 2'b01;
      CODE_NEG:  rin = 2'b11;
      CODE_ILL:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ternary_stream_feeder.sv
// Loads NUM_COEF ternary coefficients word by word, then streams them one per cycle to a
// multiplier with a one-cycle en pulse before and a one-cycle done pulse after.
module ternary_stream_feeder #(
  parameter int unsigned NUM_COEF      = ternary_stream_feeder_pkg::NUM_COEF,
  parameter int unsigned COEF_PER_WORD = ternary_stream_feeder_pkg::COEF_PER_WORD
) (
  input  logic                       lcl_clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*COEF_PER_WORD-1:0] in_data,
  input  logic                       start,
  output logic                       en,
  output logic [1:0]                 rin,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  import ternary_stream_feeder_pkg::*;

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_COEF / COEF_PER_WORD - 1);
  localparam logic [CNT_W-1:0]  LAST_COEF = CNT_W'(NUM_COEF - 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  strm_q, strm_d;
  logic              err_q, err_d;

  logic [1:0]        coef_q [NUM_COEF];

  logic              xfer;
  logic              wr_en;
  logic [WORD_W-1:0] wr_word;
  logic [CNT_W-1:0]  wr_base;

  logic [2*COEF_PER_WORD-1:0] lane_rin;
  logic [COEF_PER_WORD-1:0]   lane_ill;
  logic [2*COEF_PER_WORD-1:0] lane_code;
  logic                       word_ill;
  logic [1:0]                 out_rin;
  logic                       out_ill;

  assign xfer    = in_valid & in_ready;
  assign word_ill = |lane_ill;
  assign wr_base = CNT_W'(wr_word) * CNT_W'(COEF_PER_WORD);

  // Per-lane load-side decode; illegal codes are scrubbed to zero before storage.
  for (genvar g = 0; g < COEF_PER_WORD; g++) begin : g_lane
    ternary_decode u_load_dec (
      .code    (in_data[2*g +: 2]),
      .rin     (lane_rin[2*g +: 2]),
      .illegal (lane_ill[g])
    );
    // Re-encode the decoded pair as a canonical code: 11 -> 10, 01 -> 01, 00 -> 00.
    assign lane_code[2*g +: 2] = {lane_rin[2*g+1], lane_rin[2*g] & ~lane_rin[2*g+1]};
  end

  // Stream-side decode of the coefficient selected by the stream counter.
  ternary_decode u_out_dec (
    .code    (coef_q[strm_q]),
    .rin     (out_rin),
    .illegal (out_ill)
  );

  // Next-state, counter and error-flag logic.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    strm_d  = strm_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_word = word_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          wr_en   = 1'b1;
          wr_word = '0;
          err_d   = word_ill;
          word_d  = WORD_W'(1);
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (xfer) begin
          wr_en = 1'b1;
          err_d = err_q | word_ill;
          if (word_q == LAST_WORD) begin
            state_d = StLoaded;
          end else begin
            word_d = word_q + WORD_W'(1);
          end
        end
      end
      StLoaded: begin
        if (start) state_d = StStart;
      end
      StStart: begin
        strm_d  = '0;
        state_d = StStream;
      end
      StStream: begin
        if (strm_q == LAST_COEF) begin
          strm_d  = '0;
          state_d = StDone;
        end else begin
          strm_d = strm_q + CNT_W'(1);
        end
      end
      StDone: begin
        word_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge lcl_clk) begin
    if (rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      strm_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      strm_q  <= strm_d;
      err_q   <= err_d;
    end
  end

  // Coefficient buffer write; contents survive reset, reset only blocks a same-cycle write.
  always_ff @(posedge lcl_clk) begin
    if (wr_en && !rst) begin
      for (int j = 0; j < COEF_PER_WORD; j++) begin
        coef_q[wr_base + CNT_W'(j)] <= lane_code[2*j +: 2];
      end
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    in_ready = (state_q == StIdle) || (state_q == StLoad);
    en       = (state_q == StStart);
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    err      = err_q;
    // out_ill cannot fire: illegal codes were scrubbed on load.
    rin      = ((state_q == StStream) && !out_ill) ? out_rin : 2'b00;
  end

endmodule

// File: tb/tb_ternary_stream_feeder.sv
// Self-checking bench for ternary_stream_feeder: scoreboard queue of expected rin values.
module tb_ternary_stream_feeder;
  import ternary_stream_feeder_pkg::*;

  localparam int IW = 2 * COEF_PER_WORD;
  localparam int NW = NUM_WORDS;
  localparam int NC = NUM_COEF;

  logic          lcl_clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          start = 1'b0;
  logic          en;
  logic [1:0]    rin;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  logic [IW-1:0] img [NW];
  logic [1:0]    exp_q [$];

  ternary_stream_feeder dut (
    .lcl_clk  (lcl_clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .start    (start),
    .en       (en),
    .rin      (rin),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 lcl_clk = ~lcl_clk;

  function automatic logic [1:0] exp_rin(input logic [1:0] c);
    case (c)
      2'b01:   return 2'b01;
      2'b10:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic has_ill(input logic [IW-1:0] w);
    logic r;
    r = 1'b0;
    for (int l = 0; l < COEF_PER_WORD; l++) if (w[2*l +: 2] == 2'b11) r = 1'b1;
    return r;
  endfunction

  function automatic logic [IW-1:0] rand_legal_word();
    logic [IW-1:0] w;
    for (int l = 0; l < COEF_PER_WORD; l++) w[2*l +: 2] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  // Back-to-back load of img; optionally raises start alongside word start_at.
  task automatic load_img(input int start_at);
    logic err_m;
    err_m = 1'b0;
    for (int i = 0; i < NW; i++) begin
      in_valid = 1'b1;
      in_data  = img[i];
      start    = (i == start_at);
      @(negedge lcl_clk);
      err_m = (i == 0) ? has_ill(img[i]) : (err_m | has_ill(img[i]));
      n_checks++;
      if (err !== err_m) begin
        n_errors++;
        $display("FAIL load_err word %0d: got %b want %b", i, err, err_m);
      end
      n_checks++;
      if (en !== 1'b0) begin
        n_errors++;
        $display("FAIL load_en word %0d: got %b want 0", i, en);
      end
      n_checks++;
      if (in_ready !== (i < NW - 1)) begin
        n_errors++;
        $display("FAIL load_ready word %0d: got %b want %b", i, in_ready, (i < NW - 1));
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL loaded_busy: got %b want 1", busy);
    end
  endtask

  // Pulse start from LOADED and score the whole stream; abort_at >= 0 resets mid-stream.
  task automatic run_stream(input int abort_at, input bit noise);
    logic [1:0] e;
    start = 1'b1;
    if (noise) begin
      in_valid = 1'b1;
      in_data  = IW'($urandom);
    end
    @(negedge lcl_clk);
    start = 1'b0;
    for (int k = 0; k < NC; k++) exp_q.push_back(exp_rin(img[k / COEF_PER_WORD][2*(k % COEF_PER_WORD) +: 2]));
    n_checks++;
    if (en !== 1'b1 || rin !== 2'b00 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL start_cycle: en=%b rin=%b busy=%b want en=1 rin=00 busy=1", en, rin, busy);
    end
    for (int k = 0; k < NC; k++) begin
      if (noise) in_data = IW'($urandom);
      @(negedge lcl_clk);
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard_empty at stream cycle %0d", k);
        e = 2'bxx;
      end else begin
        e = exp_q.pop_front();
      end
      n_checks++;
      if (rin !== e) begin
        n_errors++;
        $display("FAIL stream_rin cycle %0d: got %b want %b", k, rin, e);
      end
      n_checks++;
      if (en !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL stream_ctl cycle %0d: en=%b done=%b in_ready=%b want 0/0/0", k, en, done,
                 in_ready);
      end
      if (k == abort_at) begin
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge lcl_clk);
        rst = 1'b0;
        exp_q.delete();
        n_checks++;
        if (rin !== 2'b00 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
          n_errors++;
          $display("FAIL abort: rin=%b busy=%b in_ready=%b done=%b want 00/0/1/0", rin, busy,
                   in_ready, done);
        end
        repeat (3) begin
          @(negedge lcl_clk);
          n_checks++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_after: done=%b busy=%b want 0/0", done, busy);
          end
        end
        return;
      end
    end
    in_valid = 1'b0;
    @(negedge lcl_clk);
    n_checks++;
    if (done !== 1'b1 || rin !== 2'b00 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL done_pulse: done=%b rin=%b busy=%b want 1/00/1", done, rin, busy);
    end
    @(negedge lcl_clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL after_done: done=%b busy=%b in_ready=%b want 0/0/1", done, busy, in_ready);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge lcl_clk);
    n_checks++;
    if (in_ready !== 1'b1 || en !== 1'b0 || rin !== 2'b00 || busy !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: ready=%b en=%b rin=%b busy=%b done=%b err=%b want 1/0/00/0/0/0",
               in_ready, en, rin, busy, done, err);
    end
    // rst wins over in_valid and start in the same cycle.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    start    = 1'b1;
    @(negedge lcl_clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_priority: busy=%b err=%b want 0/0", busy, err);
    end
    // start alone in IDLE does nothing.
    @(negedge lcl_clk);
    start = 1'b0;
    n_checks++;
    if (en !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_start: en=%b busy=%b want 0/0", en, busy);
    end
  endtask

  task automatic test_all_pos();
    for (int i = 0; i < NW; i++) img[i] = 8'h55;
    load_img(-1);
    run_stream(-1, 1'b0);
  endtask

  task automatic test_ends();
    for (int i = 0; i < NW; i++) img[i] = 8'h00;
    img[0]      = 8'h02;
    img[NW - 1] = 8'h40;
    load_img(-1);
    run_stream(-1, 1'b0);
  endtask

  task automatic test_illegal();
    for (int i = 0; i < NW; i++) img[i] = 8'h55;
    img[3] = 8'hC0;
    load_img(-1);
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    run_stream(-1, 1'b0);
    for (int i = 0; i < NW; i++) img[i] = rand_legal_word();
    load_img(-1);
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_cleared: got %b want 0", err);
    end
    run_stream(-1, 1'b0);
  endtask

  task automatic test_start_during_load();
    for (int i = 0; i < NW; i++) img[i] = rand_legal_word();
    load_img(100);
    run_stream(-1, 1'b0);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < NW; i++) img[i] = rand_legal_word();
    load_img(-1);
    run_stream(350, 1'b0);
  endtask

  task automatic test_no_capture();
    for (int i = 0; i < NW; i++) img[i] = rand_legal_word();
    load_img(-1);
    run_stream(-1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_all_pos();
    test_ends();
    test_illegal();
    test_start_during_load();
    test_rst_mid();
    test_no_capture();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
